// File: rtl/bcd_stopwatch_2digit.sv
// bcd_stopwatch_2digit: two-digit BCD stopwatch with debounced start/stop, clear and lap buttons.
// Rev 1.0 - initial release.
`default_nettype none

module bcd_stopwatch_2digit #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] lsd,
  output logic [3:0] msd,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_lap, btn_clear, btn_start_stop};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_prev_q;
    logic            press_q;
    logic [DB_W-1:0] stab_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        press_q      <= 1'b0;
        stab_q       <= '0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
        if (sync2_q == level_q) begin
          stab_q <= '0;
        end else if (stab_q == DB_LAST) begin
          level_q <= sync2_q;
          stab_q  <= '0;
        end else begin
          stab_q <= stab_q + DB_W'(1);
        end
        // Press pulse is registered one stage after the accepted-level edge.
        level_prev_q <= level_q;
        press_q      <= level_q & ~level_prev_q;
      end
    end

    assign press[b] = press_q;
  end

  logic press_start;
  logic press_clear;
  logic press_lap;

  assign press_start = press[0];
  assign press_clear = press[1];
  assign press_lap   = press[2];

  state_t          state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [3:0]      cnt_lo_q, cnt_lo_d;
  logic [3:0]      cnt_hi_q, cnt_hi_d;
  logic [3:0]      disp_lo_q, disp_lo_d;
  logic [3:0]      disp_hi_q, disp_hi_d;
  logic            ovf_q, ovf_d;
  logic            lap_q, lap_d;
  logic            run_q, run_d;
  logic            tick;

  assign tick = (state_q == S_RUN) && (presc_q == PS_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_lo_d  = cnt_lo_q;
    cnt_hi_d  = cnt_hi_q;
    ovf_d     = ovf_q;
    lap_d     = lap_q;
    disp_lo_d = disp_lo_q;
    disp_hi_d = disp_hi_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (press_start) state_d = S_RUN;
      end
      S_RUN: begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        if (press_start) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (press_start) state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
      end
    endcase

    if (tick) begin
      if (cnt_lo_q == 4'd9) begin
        cnt_lo_d = 4'd0;
        if (cnt_hi_q == 4'd9) begin
          cnt_hi_d = 4'd0;
          ovf_d    = 1'b1;
        end else begin
          cnt_hi_d = cnt_hi_q + 4'd1;
        end
      end else begin
        cnt_lo_d = cnt_lo_q + 4'd1;
      end
    end

    if (press_lap) begin
      if (lap_q)                  lap_d = 1'b0;
      else if (state_q == S_RUN)  lap_d = 1'b1;
    end

    // Clear overrides every other action taken in the same cycle.
    if (press_clear) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      cnt_lo_d = 4'd0;
      cnt_hi_d = 4'd0;
      ovf_d    = 1'b0;
      lap_d    = 1'b0;
    end

    if (!lap_q) begin
      disp_lo_d = cnt_lo_q;
      disp_hi_d = cnt_hi_q;
    end

    run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_lo_q  <= 4'd0;
      cnt_hi_q  <= 4'd0;
      disp_lo_q <= 4'd0;
      disp_hi_q <= 4'd0;
      ovf_q     <= 1'b0;
      lap_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_lo_q  <= cnt_lo_d;
      cnt_hi_q  <= cnt_hi_d;
      disp_lo_q <= disp_lo_d;
      disp_hi_q <= disp_hi_d;
      ovf_q     <= ovf_d;
      lap_q     <= lap_d;
      run_q     <= run_d;
    end
  end

  assign lsd      = disp_lo_q;
  assign msd      = disp_hi_q;
  assign running  = run_q;
  assign lap_hold = lap_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_stopwatch_2digit.sv
// tb_bcd_stopwatch_2digit: directed bench for the stopwatch with TICK_DIV=4, DEBOUNCE_CYCLES=2.
// Rev 1.0 - initial release.
`default_nettype none

module tb_bcd_stopwatch_2digit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] lsd;
  logic [3:0] msd;
  logic       running;
  logic       lap_hold;
  logic       overflow;

  bcd_stopwatch_2digit #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .btn_lap       (btn_lap),
    .lsd           (lsd),
    .msd           (msd),
    .running       (running),
    .lap_hold      (lap_hold),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_CLEAR = 3'b010;
  localparam logic [2:0] B_LAP   = 3'b100;

  typedef struct {
    int         n;
    logic [3:0] lsd;
    logic [3:0] msd;
    logic       run;
    logic       lap;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Returns #1 after edge number t.
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Raw buttons high for edges first .. first+hold-1.
  task automatic press(input logic [2:0] mask, input int first, input int hold);
    goto(first - 1);
    {btn_lap, btn_clear, btn_start_stop} = mask;
    goto(first + hold - 1);
    {btn_lap, btn_clear, btn_start_stop} = 3'b000;
  endtask

  task automatic check(input string name, input logic [3:0] e_lsd, input logic [3:0] e_msd,
                       input logic e_run, input logic e_lap, input logic e_ovf);
    n_cmp++;
    if ({lsd, msd, running, lap_hold, overflow} !== {e_lsd, e_msd, e_run, e_lap, e_ovf}) begin
      n_bad++;
      $display("FAIL %s: got msd/lsd=%0d%0d run=%b lap=%b ovf=%b, expected msd/lsd=%0d%0d run=%b lap=%b ovf=%b",
               name, msd, lsd, running, lap_hold, overflow, e_msd, e_lsd, e_run, e_lap, e_ovf);
    end
  endtask

  task automatic check_flags(input string name, input logic e_run, input logic e_ovf);
    n_cmp++;
    if ({running, overflow} !== {e_run, e_ovf}) begin
      n_bad++;
      $display("FAIL %s: got run=%b ovf=%b, expected run=%b ovf=%b",
               name, running, overflow, e_run, e_ovf);
    end
  endtask

  initial begin
    int t0, s1, r, r4, r6;

    // Edge offsets are relative to the edge on which RUN is first entered.
    vecs[0] = '{4,   4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5,   4'd1, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{9,   4'd2, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{37,  4'd9, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{40,  4'd9, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{41,  4'd0, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{397, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{400, 4'd9, 4'd9, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{401, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{405, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1};

    goto(2);
    check("reset_state", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    t0 = cyc;

    press(B_START, t0 + 2, 1);
    goto(t0 + 20);
    check("glitch_no_press", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    s1 = t0 + 22;
    goto(s1 - 1);
    btn_start_stop = 1'b1;
    goto(s1 + 4);
    check("start_latency_5", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    goto(s1 + 5);
    check("start_latency_6", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    r = s1 + 5;
    goto(s1 + 9);
    btn_start_stop = 1'b0;

    foreach (vecs[i]) begin
      goto(r + vecs[i].n);
      check($sformatf("count_vec%0d", i), vecs[i].lsd, vecs[i].msd,
            vecs[i].run, vecs[i].lap, vecs[i].ovf);
    end

    press(B_CLEAR, r + 410, 3);
    goto(r + 415);
    check_flags("clear_flags", 1'b0, 1'b0);
    goto(r + 416);
    check("clear_zero", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    press(B_LAP, r + 420, 3);
    goto(r + 430);
    check("lap_idle_ignored", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    press(B_START, r + 440, 3);
    r4 = r + 445;
    goto(r4);
    check("restart_run", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    press(B_LAP, r4 + 89, 3);
    goto(r4 + 94);
    check("lap_freeze_23", 4'd3, 4'd2, 1'b1, 1'b1, 1'b0);
    press(B_LAP, r4 + 97, 3);
    goto(r4 + 101);
    check("lap_still_23", 4'd3, 4'd2, 1'b1, 1'b1, 1'b0);
    goto(r4 + 103);
    check("lap_release_25", 4'd5, 4'd2, 1'b1, 1'b0, 1'b0);

    press(B_LAP | B_START, r4 + 110, 3);
    goto(r4 + 120);
    check("lap_and_pause", 4'd8, 4'd2, 1'b0, 1'b1, 1'b0);
    press(B_LAP, r4 + 125, 3);
    goto(r4 + 135);
    check("lap_off_in_pause", 4'd8, 4'd2, 1'b0, 1'b0, 1'b0);
    press(B_LAP, r4 + 140, 3);
    goto(r4 + 150);
    check("lap_pause_ignored", 4'd8, 4'd2, 1'b0, 1'b0, 1'b0);

    // Prescaler held at 3 across the pause, so the first tick follows immediately.
    press(B_START, r4 + 160, 3);
    goto(r4 + 166);
    check("resume_before_tick", 4'd8, 4'd2, 1'b1, 1'b0, 1'b0);
    goto(r4 + 167);
    check("resume_prescaler_held", 4'd9, 4'd2, 1'b1, 1'b0, 1'b0);

    press(B_START | B_CLEAR, r4 + 180, 3);
    goto(r4 + 186);
    check("clear_beats_start", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    press(B_START, r4 + 200, 3);
    r6 = r4 + 205;
    goto(r6 + 190);
    check("count_47", 4'd7, 4'd4, 1'b1, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    goto(r6 + 193);
    reset_n = 1'b1;
    goto(r6 + 210);
    check("after_reset_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
